// File: rtl/shift_unit_seq.sv
// shift_unit_seq: multi-cycle shifter that moves the operand one bit per clock.
// Modes: 00=SLL, 01=SRL, 10=SRA, 11=ROL, with valid/ready handshakes on both sides.
// Optional feature macro: SHIFT_CARRY_EN adds carry_out, the last bit shifted out.
module shift_unit_seq #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_amt,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
`ifdef SHIFT_CARRY_EN
  output logic               carry_out,
`endif
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   data_q;
  logic [WIDTH-1:0]   out_q;
  logic [SHAMT_W-1:0] count_q;
  logic [1:0]         mode_q;
  logic [WIDTH-1:0]   step_data;
  logic               accept;
  logic               stepping;
  logic               finishing;

  assign accept    = (state == IDLE) && in_valid;
  assign stepping  = (state == SHIFT) && (count_q != '0);
  assign finishing = (state == SHIFT) && (count_q == '0);
  assign out_data  = out_q;

  // State register; reset drops any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs, all decoded from the current state.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (count_q == '0) state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // One-bit step of the working operand in the captured mode.
  always_comb begin
    step_data = data_q;
    case (mode_q)
      MODE_SLL: step_data = {data_q[WIDTH-2:0], 1'b0};
      MODE_SRL: step_data = {1'b0, data_q[WIDTH-1:1]};
      MODE_SRA: step_data = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
      default:  step_data = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
    endcase
  end

  // Operand capture, per-clock stepping, and result latch on the way into DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      count_q <= '0;
      mode_q  <= '0;
      out_q   <= '0;
    end else if (accept) begin
      data_q  <= in_data;
      count_q <= in_amt;
      mode_q  <= in_mode;
    end else if (stepping) begin
      data_q  <= step_data;
      count_q <= count_q - SHAMT_W'(1);
    end else if (finishing) begin
      out_q   <= data_q;
    end
  end

`ifdef SHIFT_CARRY_EN
  logic step_bit;
  logic carry_q;
  logic carry_out_q;

  assign carry_out = carry_out_q;

  // Bit leaving the operand on this step: MSB for left moves, LSB for right moves.
  always_comb begin
    step_bit = 1'b0;
    case (mode_q)
      MODE_SLL: step_bit = data_q[WIDTH-1];
      MODE_SRL: step_bit = data_q[0];
      MODE_SRA: step_bit = data_q[0];
      default:  step_bit = data_q[WIDTH-1];
    endcase
  end

  // Track the most recent shifted-out bit and publish it alongside the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
    end else if (accept) begin
      carry_q     <= 1'b0;
    end else if (stepping) begin
      carry_q     <= step_bit;
    end else if (finishing) begin
      carry_out_q <= carry_q;
    end
  end
`endif

endmodule
